// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
//   - Op field width and op encodings driven on hilo_muldiv_unit.Op
//   - FSM state encodings used by the top level
package hilo_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_NOP   = 3'd0;
    localparam logic [OP_W-1:0] OP_MULT  = 3'd1;
    localparam logic [OP_W-1:0] OP_MULTU = 3'd2;
    localparam logic [OP_W-1:0] OP_DIV   = 3'd3;
    localparam logic [OP_W-1:0] OP_DIVU  = 3'd4;
    localparam logic [OP_W-1:0] OP_MTHI  = 3'd5;
    localparam logic [OP_W-1:0] OP_MTLO  = 3'd6;
    localparam logic [OP_W-1:0] OP_MADD  = 3'd7;

    localparam int ST_W = 2;

    localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
    localparam logic [ST_W-1:0] ST_CALC = 2'd1;
    localparam logic [ST_W-1:0] ST_FIX  = 2'd2;

endpackage

// File: rtl/hilo_iter_core.sv
// Iterative unsigned multiply / restoring-divide datapath.
//   clk, rst_n  : clock, async active-low reset
//   load        : capture a_mag/b_mag and mode, clear hi and counter
//   step        : perform one iteration (ignored while load is high)
//   div_mode    : 0 = shift-add multiply, 1 = restoring divide
//   a_mag       : multiplier / dividend magnitude
//   b_mag       : multiplicand / divisor magnitude
//   hi, lo      : product {hi,lo}, or remainder (hi) / quotient (lo)
//   cnt         : number of steps taken since load
module hilo_iter_core #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH+1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic             div_mode,
    input  logic [WIDTH-1:0] a_mag,
    input  logic [WIDTH-1:0] b_mag,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [CNT_W-1:0] cnt
);

    logic [WIDTH-1:0] hi_r, lo_r, d_r;
    logic             div_r;
    logic [CNT_W-1:0] cnt_r;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_diff;

    always_comb begin
        // Multiply: add multiplicand into the upper half when the current
        // multiplier bit (lo[0]) is set; the carry is kept for the shift.
        mul_sum  = {1'b0, hi_r} + (lo_r[0] ? {1'b0, d_r} : '0);
        // Divide: shift next dividend bit into the partial remainder and
        // trial-subtract. The extra bit covers remainders up to 2*d-1.
        rem_sh   = {hi_r, lo_r[WIDTH-1]};
        rem_diff = rem_sh - {1'b0, d_r};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_r  <= '0;
            lo_r  <= '0;
            d_r   <= '0;
            div_r <= 1'b0;
            cnt_r <= '0;
        end else if (load) begin
            hi_r  <= '0;
            lo_r  <= a_mag;
            d_r   <= b_mag;
            div_r <= div_mode;
            cnt_r <= '0;
        end else if (step) begin
            cnt_r <= cnt_r + CNT_W'(1);
            if (div_r) begin
                if (!rem_diff[WIDTH]) begin
                    hi_r <= rem_diff[WIDTH-1:0];
                    lo_r <= {lo_r[WIDTH-2:0], 1'b1};
                end else begin
                    hi_r <= rem_sh[WIDTH-1:0];
                    lo_r <= {lo_r[WIDTH-2:0], 1'b0};
                end
            end else begin
                hi_r <= mul_sum[WIDTH:1];
                lo_r <= {mul_sum[0], lo_r[WIDTH-1:1]};
            end
        end
    end

    assign hi  = hi_r;
    assign lo  = lo_r;
    assign cnt = cnt_r;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Architectural HI/LO registers with an iterative multiply/divide engine.
//   Clk, Reset   : clock, async active-low reset
//   Start, Op    : issue request (sampled only while idle), op code
//   A, B         : rs / rt operands
//   Flush        : abort an in-flight op, HI/LO untouched
//   Busy         : op in flight
//   Done         : one-cycle pulse when a multi-cycle op writes HI/LO
//   HI_output    : HI register
//   LO_output    : LO register
module hilo_muldiv_unit
    import hilo_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH+1)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [OP_W-1:0]  Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Flush,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] HI_output,
    output logic [WIDTH-1:0] LO_output
);

    logic [ST_W-1:0]  state;
    logic [WIDTH-1:0] hi_q, lo_q, a_raw;
    logic             done_q, is_div, is_madd, neg_q, neg_r, div0;

    logic             accept, signed_op, step;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] core_hi, core_lo;
    logic [CNT_W-1:0] core_cnt;

    logic [2*WIDTH-1:0] prod, prod_s, mul_res;
    logic [WIDTH-1:0]   quo, rem;

    always_comb begin
        accept    = (state == ST_IDLE) && Start &&
                    (Op == OP_MULT || Op == OP_MULTU || Op == OP_DIV ||
                     Op == OP_DIVU || Op == OP_MADD);
        signed_op = (Op == OP_MULT) || (Op == OP_DIV) || (Op == OP_MADD);
        a_mag     = (signed_op && A[WIDTH-1]) ? -A : A;
        b_mag     = (signed_op && B[WIDTH-1]) ? -B : B;
        step      = (state == ST_CALC) && !Flush;
    end

    hilo_iter_core #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_core (
        .clk      (Clk),
        .rst_n    (Reset),
        .load     (accept),
        .step     (step),
        .div_mode (Op == OP_DIV || Op == OP_DIVU),
        .a_mag    (a_mag),
        .b_mag    (b_mag),
        .hi       (core_hi),
        .lo       (core_lo),
        .cnt      (core_cnt)
    );

    // Sign fix-up. MADD accumulates onto the live HI/LO, which cannot change
    // while busy, so it equals the value seen at accept.
    always_comb begin
        prod    = {core_hi, core_lo};
        prod_s  = neg_q ? -prod : prod;
        mul_res = is_madd ? prod_s + {hi_q, lo_q} : prod_s;
        quo     = neg_q ? -core_lo : core_lo;
        rem     = neg_r ? -core_hi : core_hi;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state   <= ST_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            is_div  <= 1'b0;
            is_madd <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            div0    <= 1'b0;
            a_raw   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        is_div  <= (Op == OP_DIV) || (Op == OP_DIVU);
                        is_madd <= (Op == OP_MADD);
                        // neg_q doubles as the product sign for multiplies
                        neg_q   <= signed_op && (A[WIDTH-1] ^ B[WIDTH-1]);
                        neg_r   <= signed_op && A[WIDTH-1];
                        div0    <= (B == '0);
                        a_raw   <= A;
                        state   <= ST_CALC;
                    end else if (Start && Op == OP_MTHI) begin
                        hi_q <= A;
                    end else if (Start && Op == OP_MTLO) begin
                        lo_q <= A;
                    end
                end
                ST_CALC: begin
                    if (Flush)
                        state <= ST_IDLE;
                    else if (core_cnt == CNT_W'(WIDTH-1))
                        state <= ST_FIX;
                end
                ST_FIX: begin
                    state <= ST_IDLE;
                    if (!Flush) begin
                        done_q <= 1'b1;
                        if (!is_div) begin
                            {hi_q, lo_q} <= mul_res;
                        end else if (div0) begin
                            // Divide by zero bypasses sign fix-up entirely.
                            hi_q <= a_raw;
                            lo_q <= '1;
                        end else begin
                            hi_q <= rem;
                            lo_q <= quo;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign Busy      = (state != ST_IDLE);
    assign Done      = done_q;
    assign HI_output = hi_q;
    assign LO_output = lo_q;

endmodule
